// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - decode-stage bus for the register file / write-back scoreboard
//
// Purpose: bundles the read ports, the write-back port, the issue request and
// the scoreboard status outputs of reg_file_sb into one interface.
//   master : decode / write-back side (drives addresses, write-back, issue)
//   slave  : reg_file_sb (drives read data, issue_ready, hazard, busy, err)
// Signals:
//   rd_addr     NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_use      NUM_RD         port i operand is consumed (hazard-checked)
//   rd_data     NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
//   wr_en/wr_addr/wr_data      write-back port
//   issue_en/issue_wb/issue_dest  issue request from decode
//   issue_ready/hazard/busy/err   scoreboard status
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0]        rd_use;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     issue_en;
  logic                     issue_wb;
  logic [ADDR_W-1:0]        issue_dest;
  logic                     issue_ready;
  logic                     hazard;
  logic                     busy;
  logic                     err;

  modport master (
    output rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_wb, issue_dest,
    input  rd_data, issue_ready, hazard, busy, err
  );

  modport slave (
    input  rd_addr, rd_use, wr_en, wr_addr, wr_data, issue_en, issue_wb, issue_dest,
    output rd_data, issue_ready, hazard, busy, err
  );
endinterface

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with integrated write-back scoreboard
//
// Purpose: architectural register file for the decode stage. Serves NUM_RD
// combinational read ports (optional same-cycle write-through bypass) and
// tracks in-flight destination writes with a pending counter per register.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-low reset
//   sb_if  reg_file_sb_if.slave: read ports, write-back port, issue request,
//          issue_ready / hazard / busy / err status
// Parameters: DATA_W, ADDR_W (NUM_REGS = 2**ADDR_W), NUM_RD (1..4),
//   CNT_W (max in-flight writes per register = 2**CNT_W-1), BYPASS (1 = on).
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave sb_if
);
  localparam int               NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit               BYP_EN   = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
  logic              err_q, err_d;

  logic [ADDR_W-1:0] rd_a   [NUM_RD];
  logic [NUM_RD-1:0] rd_byp;
  logic [NUM_RD-1:0] rd_haz;
  logic [NUM_REGS-1:0] inc_v, dec_v, nz_v;

  logic hazard_c, full_c, ready_c, accept_c;

  // Read ports. A bypassed write-back also retires one pending write for
  // the hazard check, so a source with exactly one outstanding write that
  // is being written back this cycle is usable immediately.
  always_comb begin
    sb_if.rd_data = '0;
    rd_byp        = '0;
    rd_haz        = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_a[i] = sb_if.rd_addr[i*ADDR_W +: ADDR_W];
    end
    for (int i = 0; i < NUM_RD; i++) begin
      rd_byp[i] = BYP_EN && sb_if.wr_en && (sb_if.wr_addr == rd_a[i]);
      sb_if.rd_data[i*DATA_W +: DATA_W] = rd_byp[i] ? sb_if.wr_data : regs_q[rd_a[i]];
      rd_haz[i] = sb_if.rd_use[i] && (cnt_q[rd_a[i]] != '0)
                  && !(rd_byp[i] && (cnt_q[rd_a[i]] == CNT_ONE));
    end
  end

  assign hazard_c = |rd_haz;

  // A saturated destination may still issue when the same register is being
  // written back this cycle: the increment and decrement cancel.
  assign full_c   = sb_if.issue_wb && (cnt_q[sb_if.issue_dest] == CNT_MAX)
                    && !(sb_if.wr_en && (sb_if.wr_addr == sb_if.issue_dest));
  assign ready_c  = !hazard_c && !full_c;
  assign accept_c = sb_if.issue_en && ready_c && sb_if.issue_wb;

  // Pending counter next state and sticky error.
  always_comb begin
    err_d = err_q;
    inc_v = '0;
    dec_v = '0;
    nz_v  = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      nz_v[r]  = (cnt_q[r] != '0);
      inc_v[r] = accept_c && (sb_if.issue_dest == ADDR_W'(r));
      dec_v[r] = sb_if.wr_en && (sb_if.wr_addr == ADDR_W'(r)) && nz_v[r];
      if (inc_v[r] && !dec_v[r]) begin
        // Unreachable through this port set (full_c refuses the issue);
        // kept so a wrapping counter can never go unnoticed.
        if (cnt_q[r] == CNT_MAX) begin
          err_d = 1'b1;
        end else begin
          cnt_d[r] = cnt_q[r] + CNT_ONE;
        end
      end else if (dec_v[r] && !inc_v[r]) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
    // Write-back with nothing pending: data is still written, flag it.
    if (sb_if.wr_en && (cnt_q[sb_if.wr_addr] == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      err_q <= 1'b0;
    end else begin
      if (sb_if.wr_en) begin
        regs_q[sb_if.wr_addr] <= sb_if.wr_data;
      end
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_d;
    end
  end

  assign sb_if.hazard      = hazard_c;
  assign sb_if.issue_ready = ready_c;
  assign sb_if.busy        = |nz_v;
  assign sb_if.err         = err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3)) bus3 ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) bus2 ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .CNT_W(2), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .sb_if(bus3.slave));

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .CNT_W(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .sb_if(bus2.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        issue_en;
    logic        issue_wb;
    logic [3:0]  issue_dest;
    logic [11:0] rd_addr;
    logic [2:0]  rd_use;
    logic [31:0] e_d0, e_d1, e_d2;
    logic        e_hz, e_rdy, e_busy, e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                              input logic ie, input logic iw, input logic [3:0] id,
                              input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                              input logic [2:0] use_v,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic hz, input logic rdy, input logic bsy, input logic er);
    vec_t v;
    v.wr_en = we; v.wr_addr = wa; v.wr_data = wd;
    v.issue_en = ie; v.issue_wb = iw; v.issue_dest = id;
    v.rd_addr = {a2, a1, a0}; v.rd_use = use_v;
    v.e_d0 = d0; v.e_d1 = d1; v.e_d2 = d2;
    v.e_hz = hz; v.e_rdy = rdy; v.e_busy = bsy; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle3();
    bus3.wr_en = 0; bus3.wr_addr = 0; bus3.wr_data = 0;
    bus3.issue_en = 0; bus3.issue_wb = 0; bus3.issue_dest = 0;
    bus3.rd_addr = 0; bus3.rd_use = 0;
  endtask

  task automatic idle2();
    bus2.wr_en = 0; bus2.wr_addr = 0; bus2.wr_data = 0;
    bus2.issue_en = 0; bus2.issue_wb = 0; bus2.issue_dest = 0;
    bus2.rd_addr = 0; bus2.rd_use = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle3();
    idle2();

    // issue / write-back on the bypassing DUT
    tbl.push_back(mk(0,0,0,            1,1,5, 5,0,0,3'b000, 0,0,0,                 0,1,0,0));
    tbl.push_back(mk(0,0,0,            0,0,0, 5,0,0,3'b001, 0,0,0,                 1,0,1,0));
    tbl.push_back(mk(0,0,0,            1,1,6, 5,0,0,3'b001, 0,0,0,                 1,0,1,0));
    tbl.push_back(mk(1,5,32'h12345678, 0,0,0, 5,0,0,3'b001, 32'h12345678,0,0,      0,1,1,0));
    tbl.push_back(mk(0,0,0,            0,0,0, 5,0,0,3'b001, 32'h12345678,0,0,      0,1,0,0));
    // saturation on r2
    tbl.push_back(mk(0,0,0,            1,1,2, 2,0,0,3'b000, 0,0,0,                 0,1,0,0));
    tbl.push_back(mk(0,0,0,            1,1,2, 2,0,0,3'b000, 0,0,0,                 0,1,1,0));
    tbl.push_back(mk(0,0,0,            1,1,2, 2,0,0,3'b000, 0,0,0,                 0,1,1,0));
    tbl.push_back(mk(0,0,0,            1,1,2, 2,0,0,3'b000, 0,0,0,                 0,0,1,0));
    tbl.push_back(mk(1,2,32'h55,       1,1,2, 2,0,0,3'b000, 32'h55,0,0,            0,1,1,0));
    tbl.push_back(mk(0,0,0,            1,1,2, 2,0,0,3'b000, 32'h55,0,0,            0,0,1,0));
    // drain r2: count 3 with bypass still leaves two pending
    tbl.push_back(mk(1,2,32'h66,       0,0,0, 2,0,0,3'b001, 32'h66,0,0,            1,0,1,0));
    tbl.push_back(mk(1,2,32'h77,       0,0,0, 2,0,0,3'b000, 32'h77,0,0,            0,1,1,0));
    tbl.push_back(mk(1,2,32'h88,       0,0,0, 2,0,0,3'b001, 32'h88,0,0,            0,1,1,0));
    tbl.push_back(mk(0,0,0,            0,0,0, 2,0,0,3'b001, 32'h88,0,0,            0,1,0,0));
    // underflow on r7
    tbl.push_back(mk(1,7,32'hA5,       0,0,0, 7,0,0,3'b000, 32'hA5,0,0,            0,1,0,0));
    tbl.push_back(mk(0,0,0,            0,0,0, 7,0,0,3'b000, 32'hA5,0,0,            0,1,0,1));
    // multi-port: r1 pending, ports read r1, r2, r1
    tbl.push_back(mk(0,0,0,            1,1,1, 1,2,1,3'b000, 0,32'h88,0,            0,1,0,1));
    tbl.push_back(mk(0,0,0,            0,0,0, 1,2,1,3'b010, 0,32'h88,0,            0,1,1,1));
    tbl.push_back(mk(0,0,0,            0,0,0, 1,2,1,3'b011, 0,32'h88,0,            1,0,1,1));
    tbl.push_back(mk(0,0,0,            0,0,0, 1,2,1,3'b100, 0,32'h88,0,            1,0,1,1));
    tbl.push_back(mk(1,1,32'h11,       0,0,0, 1,2,1,3'b101, 32'h11,32'h88,32'h11,  0,1,1,1));
    tbl.push_back(mk(0,0,0,            0,0,0, 1,2,1,3'b111, 32'h11,32'h88,32'h11,  0,1,0,1));
    // r0 is general purpose
    tbl.push_back(mk(1,0,32'hCAFE,     0,0,0, 0,0,0,3'b111, 32'hCAFE,32'hCAFE,32'hCAFE, 0,1,0,1));
    tbl.push_back(mk(0,0,0,            0,0,0, 0,0,0,3'b111, 32'hCAFE,32'hCAFE,32'hCAFE, 0,1,0,1));

    // reset with write-back and issue asserted: both must be ignored
    tick();
    rst = 1'b0;
    bus3.wr_en = 1; bus3.wr_addr = 3; bus3.wr_data = 32'hDEADBEEF;
    bus3.issue_en = 1; bus3.issue_wb = 1; bus3.issue_dest = 3;
    bus2.wr_en = 1; bus2.wr_addr = 3; bus2.wr_data = 32'hDEADBEEF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle3(); idle2();
    bus3.rd_addr = 12'h003; bus3.rd_use = 3'b001;
    bus2.rd_addr = 8'h03;   bus2.rd_use = 2'b01;
    @(negedge clk);
    chk("rst_rd_data0",  bus3.rd_data[31:0], 32'h0);
    chk("rst_busy",      32'(bus3.busy), 32'h0);
    chk("rst_err",       32'(bus3.err), 32'h0);
    chk("rst_hazard",    32'(bus3.hazard), 32'h0);
    chk("rst_ready",     32'(bus3.issue_ready), 32'h1);
    chk("rst_nb_rd0",    bus2.rd_data[31:0], 32'h0);
    chk("rst_nb_busy",   32'(bus2.busy), 32'h0);
    chk("rst_nb_err",    32'(bus2.err), 32'h0);

    // table-driven sequence on the bypassing, three-port DUT
    for (int k = 0; k < tbl.size(); k++) begin
      tick();
      bus3.wr_en = tbl[k].wr_en; bus3.wr_addr = tbl[k].wr_addr; bus3.wr_data = tbl[k].wr_data;
      bus3.issue_en = tbl[k].issue_en; bus3.issue_wb = tbl[k].issue_wb;
      bus3.issue_dest = tbl[k].issue_dest;
      bus3.rd_addr = tbl[k].rd_addr; bus3.rd_use = tbl[k].rd_use;
      @(negedge clk);
      chk($sformatf("row%0d_rd_data0", k), bus3.rd_data[31:0],  tbl[k].e_d0);
      chk($sformatf("row%0d_rd_data1", k), bus3.rd_data[63:32], tbl[k].e_d1);
      chk($sformatf("row%0d_rd_data2", k), bus3.rd_data[95:64], tbl[k].e_d2);
      chk($sformatf("row%0d_hazard", k),   32'(bus3.hazard),      32'(tbl[k].e_hz));
      chk($sformatf("row%0d_ready", k),    32'(bus3.issue_ready), 32'(tbl[k].e_rdy));
      chk($sformatf("row%0d_busy", k),     32'(bus3.busy),        32'(tbl[k].e_busy));
      chk($sformatf("row%0d_err", k),      32'(bus3.err),         32'(tbl[k].e_err));
    end
    tick();
    idle3();

    // no-bypass DUT: write visible only after the write edge
    bus2.issue_en = 1; bus2.issue_wb = 1; bus2.issue_dest = 5;
    @(negedge clk);
    chk("nb_c0_ready", 32'(bus2.issue_ready), 32'h1);
    tick();
    idle2();
    bus2.rd_addr = 8'h05; bus2.rd_use = 2'b01;
    @(negedge clk);
    chk("nb_c1_hazard", 32'(bus2.hazard), 32'h1);
    chk("nb_c1_ready",  32'(bus2.issue_ready), 32'h0);
    tick();
    tick();
    bus2.wr_en = 1; bus2.wr_addr = 5; bus2.wr_data = 32'h12345678;
    @(negedge clk);
    chk("nb_c3_hazard",  32'(bus2.hazard), 32'h1);
    chk("nb_c3_rd_data", bus2.rd_data[31:0], 32'h0);
    chk("nb_c3_busy",    32'(bus2.busy), 32'h1);
    tick();
    bus2.wr_en = 0;
    @(negedge clk);
    chk("nb_c4_hazard",  32'(bus2.hazard), 32'h0);
    chk("nb_c4_rd_data", bus2.rd_data[31:0], 32'h12345678);
    chk("nb_c4_busy",    32'(bus2.busy), 32'h0);
    chk("nb_c4_ready",   32'(bus2.issue_ready), 32'h1);
    chk("nb_c4_err",     32'(bus2.err), 32'h0);
    tick();
    idle2();

    // mid-operation reset discards pending counts; the late write-back then sets err
    bus3.issue_en = 1; bus3.issue_wb = 1; bus3.issue_dest = 4;
    tick();
    idle3();
    @(negedge clk);
    chk("mid_busy_before", 32'(bus3.busy), 32'h1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    bus3.rd_addr = 12'h004;
    @(negedge clk);
    chk("mid_busy_after",  32'(bus3.busy), 32'h0);
    chk("mid_err_after",   32'(bus3.err), 32'h0);
    chk("mid_r0_cleared",  bus3.rd_data[31:0], 32'h0);
    tick();
    bus3.wr_en = 1; bus3.wr_addr = 4; bus3.wr_data = 32'h44;
    @(negedge clk);
    chk("late_wb_err_same", 32'(bus3.err), 32'h0);
    tick();
    bus3.wr_en = 0;
    @(negedge clk);
    chk("late_wb_err",  32'(bus3.err), 32'h1);
    chk("late_wb_data", bus3.rd_data[31:0], 32'h44);
    chk("late_wb_busy", 32'(bus3.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with integrated write-back scoreboard for the decode stage. It holds the architectural registers, serves NUM_RD combinational read ports with optional same-cycle write-through bypass, and tracks in-flight destination writes with per-register pending counters. From these counters it raises `hazard` and `issue_ready` to the decode stage. It sits between the instruction decoder and the pipeline register that feeds execute, with the write port driven by the write-back stage.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 4, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of read ports, legal range 1..4
- CNT_W, 2, pending-counter width; max in-flight writes per register = 2**CNT_W-1
- BYPASS, 1, 1 = same-cycle write-through to read ports; 0 = no bypass
---
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_use  in  NUM_RD  port i operand is actually consumed (hazard-checked)
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- wr_en  in  1  write-back valid
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- issue_en  in  1  decode wants to issue this cycle
- issue_wb  in  1  issued instruction will write a register
- issue_dest  in  ADDR_W  destination of issued instruction
- issue_ready  out  1  issue accepted this cycle if issue_en is high
- hazard  out  1  at least one used source is pending
- busy  out  1  any pending counter non-zero
- err  out  1  sticky: underflow or overflow attempted

## Operation
- State: regs[NUM_REGS] of DATA_W bits, cnt[NUM_REGS] of CNT_W bits, err.
- Read, combinational: rd_data[i] = (BYPASS && wr_en && wr_addr==rd_addr[i]) ? wr_data : regs[rd_addr[i]].
- Effective pending per port: eff[i] = cnt[rd_addr[i]] − (BYPASS && wr_en && wr_addr==rd_addr[i] && cnt[rd_addr[i]]!=0 ? 1 : 0).
- hazard = OR over i of (rd_use[i] && eff[i]!=0).
- full = issue_wb && cnt[issue_dest]==max && !(wr_en && wr_addr==issue_dest).
- issue_ready = !hazard && !full.
- accept = issue_en && issue_ready && issue_wb.
- Write: on wr_en, regs[wr_addr] <= wr_data at the clock edge.
- Counter update per register r: inc = accept && issue_dest==r; dec = wr_en && wr_addr==r && cnt[r]!=0.
  - inc only: cnt+1.
  - dec only: cnt−1.
  - Both: unchanged.
- Underflow: wr_en to a register with cnt==0 still writes regs; cnt stays 0; err <= 1.
- Overflow: issue_en && issue_wb && full is refused (issue_ready=0); cnt is not changed; err is not set. err is set only if a caller forces overflow, which cannot occur through this port set, so the overflow term is reserved.
- busy = OR of all cnt != 0.
- All registers, including address 0, are general purpose. No hardwired zero.

## Timing
- Reset: while rst==0 at a rising edge, all regs <= 0, all cnt <= 0, err <= 0. wr_en and issue_en are ignored in that cycle.
- Reset values (cycle after reset): rd_data = 0 for all ports, hazard=0, issue_ready=1 (given rd_use-independent), busy=0, err=0.
- Reset mid-operation discards all pending counts; late write-backs of pre-reset instructions then set err.
- Read latency is 0 (combinational).
- Write visibility:
  - BYPASS=1: visible in the same cycle.
  - BYPASS=0: visible in the cycle after the write edge.
- Issue takes effect at the next edge. A source equal to the destination issued in cycle N sees the hazard from cycle N+1.
- hazard and issue_ready are combinational from the current-cycle inputs and state. The decoder must hold issue_en and operands while issue_ready==0.
- Simultaneous issue and write-back to the same register in the same cycle: the counter is unchanged, and the write is still performed.

## Test plan
- Reset: apply rst=0 for 2 cycles with wr_en=1, wr_addr=3, wr_data=0xDEADBEEF. After release, rd_addr0=3 → rd_data0=0, busy=0, err=0.
- Issue then write-back (BYPASS=1): issue r5 in cycle 0. Cycle 1: rd_addr0=5, rd_use0=1 → hazard=1, issue_ready=0. Cycle 3: wr_en r5=0x12345678 → same cycle hazard=0, rd_data0=0x12345678. Cycle 4: busy=0.
- Same test with BYPASS=0: hazard clears and data appears one cycle after the write edge.
- Saturation (CNT_W=2): issue r2 three times → cnt=3. Fourth issue_en with issue_dest=2 → issue_ready=0. Same cycle wr_en r2 → issue_ready=1 and cnt stays 3.
- Underflow: wr_en to r7 with cnt=0, data 0xA5 → regs[7]=0xA5, err=1 and stays 1 until reset.
- Multi-port (NUM_RD=3): pending r1 only. Ports read r1, r2, r1 with rd_use=3'b010 → hazard=0. Set rd_use=3'b011 → hazard=1.
